tqvp_bus_initiator: RTL and testbench

- Master for the TinyQV peripheral data bus: turns single read/write commands on a valid/ready port into TinyQV-style strobes (address, write data, data_write_n, data_read_n) toward one peripheral.
- Waits for data_ready, then returns read data or a timeout/error status on a valid/ready response port.
- Used by the loader/debug path to program and poll peripherals such as the PRISM block without the RISC-V core.

---
 rtl/tqvp_bus_pkg.sv | 30 +++
 rtl/tqvp_bus_initiator.sv | 150 +++++++++++++++
 tb/tb_tqvp_bus_initiator.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/tqvp_bus_pkg.sv
// Shared definitions for the TinyQV peripheral bus initiator:
// access size encodings, the FSM state type and the read-data lane mask.
package tqvp_bus_pkg;

    // Access size codes, also driven directly onto the bus strobes.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_NONE = 2'b11;

    // A strobe at SZ_NONE means "no access in progress".
    localparam logic [1:0] STROBE_IDLE = SZ_NONE;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    // Zero-extension mask for read data of the given access size.
    function automatic logic [31:0] lane_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: lane_mask = 32'h0000_00FF;
            SZ_HALF: lane_mask = 32'h0000_FFFF;
            SZ_WORD: lane_mask = 32'hFFFF_FFFF;
            default: lane_mask = 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/tqvp_bus_initiator.sv
// TinyQV peripheral bus initiator: accepts one read/write command at a time,
// drives address/data/strobes to a single peripheral until data_ready or a
// timeout, then presents the result on a valid/ready response port.
// TIMEOUT_CYCLES must be 2..255 and fit in CNT_W bits.
module tqvp_bus_initiator
    import tqvp_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_size,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        rsp_error,

    output logic [5:0]  address,
    output logic [31:0] data_in,
    output logic [1:0]  data_write_n,
    output logic [1:0]  data_read_n,
    input  logic [31:0] data_out,
    input  logic        data_ready
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [5:0]        addr_d;
    logic [31:0]       wdat_d;
    logic [1:0]        wr_n_d, rd_n_d;
    logic              vld_d, to_d, err_d;
    logic [31:0]       rdata_d;
    logic              rd_active;

    // Command acceptance depends only on state so cmd_valid never loops back.
    assign cmd_ready = (state_q == IDLE) && !rst;

    // The read strobe carries the access size, so it doubles as the mask select.
    assign rd_active = (data_read_n != STROBE_IDLE);

    // Next-state and next-register logic; everything holds unless changed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = address;
        wdat_d  = data_in;
        wr_n_d  = data_write_n;
        rd_n_d  = data_read_n;
        vld_d   = rsp_valid;
        rdata_d = rsp_rdata;
        to_d    = rsp_timeout;
        err_d   = rsp_error;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_size == SZ_NONE) begin
                        // Illegal size: answer immediately, never touch the bus.
                        vld_d   = 1'b1;
                        err_d   = 1'b1;
                        to_d    = 1'b0;
                        rdata_d = 32'h0;
                        state_d = RESP;
                    end else begin
                        addr_d = cmd_addr;
                        wdat_d = cmd_wdata;
                        if (cmd_write) wr_n_d = cmd_size;
                        else           rd_n_d = cmd_size;
                        cnt_d   = '0;
                        state_d = ACCESS;
                    end
                end
            end

            ACCESS: begin
                // data_ready takes precedence over an expiring timeout.
                if (data_ready) begin
                    rdata_d = rd_active ? (data_out & lane_mask(data_read_n)) : 32'h0;
                    wr_n_d  = STROBE_IDLE;
                    rd_n_d  = STROBE_IDLE;
                    vld_d   = 1'b1;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = 32'h0;
                    to_d    = 1'b1;
                    wr_n_d  = STROBE_IDLE;
                    rd_n_d  = STROBE_IDLE;
                    vld_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    vld_d   = 1'b0;
                    to_d    = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                wr_n_d  = STROBE_IDLE;
                rd_n_d  = STROBE_IDLE;
            end
        endcase
    end

    // State, counter, bus and response registers; reset drops any pending access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            address      <= 6'h0;
            data_in      <= 32'h0;
            data_write_n <= STROBE_IDLE;
            data_read_n  <= STROBE_IDLE;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'h0;
            rsp_timeout  <= 1'b0;
            rsp_error    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            address      <= addr_d;
            data_in      <= wdat_d;
            data_write_n <= wr_n_d;
            data_read_n  <= rd_n_d;
            rsp_valid    <= vld_d;
            rsp_rdata    <= rdata_d;
            rsp_timeout  <= to_d;
            rsp_error    <= err_d;
        end
    end

endmodule

// File: tb/tb_tqvp_bus_initiator.sv
// Directed bench for tqvp_bus_initiator: a table of single accesses plus
// hand-written back-to-back and stall/reset sequences.
module tb_tqvp_bus_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [1:0]  cmd_size = 2'b00;
    logic [5:0]  cmd_addr = 6'h0;
    logic [31:0] cmd_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        rsp_error;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out = 32'h0;
    logic        data_ready = 1'b0;

    int nchk = 0;
    int errs = 0;
    int cur_vec = -1;
    logic viol = 1'b0;

    tqvp_bus_initiator #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_timeout(rsp_timeout), .rsp_error(rsp_error),
        .address(address), .data_in(data_in), .data_write_n(data_write_n),
        .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready)
    );

    always #5 clk = ~clk;

    // Both strobes active at once is a bus protocol violation.
    always @(negedge clk) begin
        if (data_write_n != 2'b11 && data_read_n != 2'b11) viol <= 1'b1;
    end

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] dout;
        int          rdy_at;
        int          cycles;
        logic [31:0] exp_rdata;
        logic        exp_to;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s vec=%0d got=0x%08h want=0x%08h", name, cur_vec, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [1:0] exp_wr, exp_rd;
        int k;
        exp_wr = v.write ? v.size : 2'b11;
        exp_rd = v.write ? 2'b11 : v.size;
        chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_size  = v.size;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        tick();
        cmd_valid = 1'b0;
        k = 0;
        if (v.exp_err) begin
            chk("err_wr_strobe", {30'b0, data_write_n}, 32'd3);
            chk("err_rd_strobe", {30'b0, data_read_n}, 32'd3);
        end else begin
            while (!rsp_valid && k < 40) begin
                chk("acc_wr_strobe", {30'b0, data_write_n}, {30'b0, exp_wr});
                chk("acc_rd_strobe", {30'b0, data_read_n}, {30'b0, exp_rd});
                chk("acc_address", {26'b0, address}, {26'b0, v.addr});
                chk("acc_data_in", data_in, v.wdata);
                data_out   = (k == v.rdy_at) ? v.dout : ~v.dout;
                data_ready = (k == v.rdy_at);
                tick();
                data_ready = 1'b0;
                k++;
            end
            chk("access_cycles", k, v.cycles);
        end
        chk("rsp_wr_idle", {30'b0, data_write_n}, 32'd3);
        chk("rsp_rd_idle", {30'b0, data_read_n}, 32'd3);
        chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, v.exp_to});
        chk("rsp_error", {31'b0, rsp_error}, {31'b0, v.exp_err});
        if (!v.exp_err) chk("addr_hold", {26'b0, address}, {26'b0, v.addr});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_drop", {31'b0, rsp_valid}, 32'd0);
        chk("flags_clear", {30'b0, rsp_timeout, rsp_error}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           wr    size   addr   wdata          dout          rdy  cyc  rdata          to    err
        vecs[0] = '{1'b1, 2'b10, 6'h28, 32'hA5A5_1234, 32'h0,        0,   1,   32'h0,         1'b0, 1'b0};
        vecs[1] = '{1'b0, 2'b00, 6'h00, 32'h0,         32'hDEAD_BEEF, 0,  1,   32'h0000_00EF, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 2'b01, 6'h00, 32'h0,         32'hDEAD_BEEF, 0,  1,   32'h0000_BEEF, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 2'b10, 6'h11, 32'h0,         32'h1234_5678, 3,  4,   32'h1234_5678, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 2'b00, 6'h07, 32'h0,         32'h0000_CAFE, 255, 16, 32'h0,         1'b1, 1'b0};
        vecs[5] = '{1'b1, 2'b01, 6'h15, 32'h0BAD_F00D, 32'h0,        15,  16,  32'h0,         1'b0, 1'b0};
        vecs[6] = '{1'b0, 2'b11, 6'h3C, 32'h0,         32'hFFFF_FFFF, 0,  0,   32'h0,         1'b0, 1'b1};
        vecs[7] = '{1'b1, 2'b00, 6'h3F, 32'hFFFF_FFFF, 32'h0,        2,   3,   32'h0,         1'b0, 1'b0};

        // Reset state
        tick();
        tick();
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        chk("rst_strobes", {28'b0, data_write_n, data_read_n}, 32'hF);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_address", {26'b0, address}, 32'd0);
        chk("rst_data_in", data_in, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'b0, cmd_ready}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            cur_vec = i;
            run_vec(vecs[i]);
        end
        cur_vec = -1;

        // Back-to-back writes with a zero-wait peripheral and rsp_ready held.
        data_ready = 1'b1;
        rsp_ready  = 1'b1;
        cmd_valid  = 1'b1;
        cmd_write  = 1'b1;
        cmd_size   = 2'b10;
        cmd_addr   = 6'h05;
        cmd_wdata  = 32'h1111_0000;
        tick();
        chk("b2b_t0_strobe", {30'b0, data_write_n}, 32'd2);
        chk("b2b_t0_ready", {31'b0, cmd_ready}, 32'd0);
        cmd_wdata = 32'h2222_0000;
        tick();
        chk("b2b_t1_strobe", {30'b0, data_write_n}, 32'd3);
        chk("b2b_t1_valid", {31'b0, rsp_valid}, 32'd1);
        chk("b2b_t1_ready", {31'b0, cmd_ready}, 32'd0);
        tick();
        chk("b2b_t2_strobe", {30'b0, data_write_n}, 32'd3);
        chk("b2b_t2_valid", {31'b0, rsp_valid}, 32'd0);
        chk("b2b_t2_ready", {31'b0, cmd_ready}, 32'd1);
        tick();
        chk("b2b_t3_strobe", {30'b0, data_write_n}, 32'd2);
        chk("b2b_t3_data", data_in, 32'h2222_0000);
        cmd_valid = 1'b0;
        tick();
        tick();
        data_ready = 1'b0;
        rsp_ready  = 1'b0;
        chk("b2b_idle_addr", {26'b0, address}, 32'h05);
        chk("b2b_idle_ready", {31'b0, cmd_ready}, 32'd1);

        // Stalled response stays stable, then reset aborts a later access.
        data_ready = 1'b1;
        data_out   = 32'h1122_3344;
        cmd_valid  = 1'b1;
        cmd_write  = 1'b0;
        cmd_size   = 2'b10;
        cmd_addr   = 6'h09;
        tick();
        cmd_valid = 1'b0;
        tick();
        data_ready = 1'b0;
        data_out   = 32'h5555_5555;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'b0, rsp_valid}, 32'd1);
            chk("stall_rdata", rsp_rdata, 32'h1122_3344);
            chk("stall_flags", {30'b0, rsp_timeout, rsp_error}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_size  = 2'b01;
        cmd_addr  = 6'h2A;
        tick();
        cmd_valid = 1'b0;
        chk("rabort_strobe", {30'b0, data_read_n}, 32'd1);
        tick();
        rst = 1'b1;
        #1;
        chk("rabort_ready_in_rst", {31'b0, cmd_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rabort_strobes", {28'b0, data_write_n, data_read_n}, 32'hF);
        chk("rabort_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rabort_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rabort_address", {26'b0, address}, 32'd0);
        tick();
        chk("rabort_still_idle", {28'b0, data_write_n, data_read_n}, 32'hF);

        chk("strobe_exclusive", {31'b0, viol}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, errs);
        $finish;
    end

endmodule
